// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg : shared types, constants and glyph helper for score_counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [3:0]  BLANK_ADDR = 4'd10;
    localparam logic [15:0] MAX_SCORE  = 16'h9999;

    // Units always shows its value; higher digits blank when they and everything above are zero.
    function automatic logic [3:0] glyph_addr(input logic [15:0] num, input logic [1:0] idx);
        logic [3:0] addr;
        addr = num[3:0];
        case (idx)
            2'd1: addr = (num[15:4]  == 12'd0) ? BLANK_ADDR : num[7:4];
            2'd2: addr = (num[15:8]  == 8'd0)  ? BLANK_ADDR : num[11:8];
            2'd3: addr = (num[15:12] == 4'd0)  ? BLANK_ADDR : num[15:12];
            default: addr = num[3:0];
        endcase
        return addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_counter_bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit : one decade of a BCD counter with clear, increment and carry-out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    input  logic       enable,
    output bcd_digit_t value,
    output logic       carry
);

    // Carry reflects the requested increment so the parent can veto a wrap via enable.
    assign carry = inc && (value == 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (inc && enable) begin
            value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_counter.sv
// ---------------------------------------------------------------------------
// score_counter : game score with prescaled frame ticks, high score and digit mux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module score_counter
    import score_pkg::*;
#(
    parameter int TICKS_PER_POINT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        game_start,
    input  logic        game_over,
    input  logic [2:0]  digit_sel,
    output logic [3:0]  digit_addr,
    output logic [15:0] score_bcd,
    output logic [15:0] hi_bcd,
    output logic        running,
    output logic        milestone
);

    localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_POINT - 1);

    state_t      state;
    logic [7:0]  prescaler;
    logic [15:0] score;
    logic [3:0]  inc;
    logic [3:0]  carry;
    logic        start_req;
    logic        run_tick;
    logic        point;
    logic        score_step;

    assign start_req = (state != RUN) && game_start;
    assign run_tick  = (state == RUN) && tick && !game_over;
    assign point     = run_tick && (prescaler == LAST_TICK);

    // A carry out of the thousands means 9999: freeze every digit instead of wrapping.
    assign score_step = !carry[3];
    assign inc        = {carry[2:0], point};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_digits
            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .clear  (start_req),
                .inc    (inc[i]),
                .enable (score_step),
                .value  (score[4*i +: 4]),
                .carry  (carry[i])
            );
        end
    endgenerate

    assign score_bcd = score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            running    <= 1'b0;
            prescaler  <= 8'd0;
            hi_bcd     <= 16'h0000;
            milestone  <= 1'b0;
            digit_addr <= 4'd0;
        end else begin
            // Tens carry means the new score ends in 00.
            milestone  <= score_step && carry[1];
            digit_addr <= glyph_addr(digit_sel[2] ? hi_bcd : score, digit_sel[1:0]);

            case (state)
                IDLE, OVER: begin
                    if (game_start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        prescaler <= 8'd0;
                    end
                end
                RUN: begin
                    if (game_over) begin
                        state   <= OVER;
                        running <= 1'b0;
                        if (score > hi_bcd) begin
                            hi_bcd <= score;
                        end
                    end else if (run_tick) begin
                        prescaler <= point ? 8'd0 : prescaler + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_counter.sv
// ---------------------------------------------------------------------------
// tb_score_counter : directed self-checking bench for score_counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_score_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        game_start = 1'b0;
    logic        game_over = 1'b0;
    logic [2:0]  digit_sel = 3'd0;
    logic [3:0]  digit_addr;
    logic [15:0] score_bcd;
    logic [15:0] hi_bcd;
    logic        running;
    logic        milestone;

    int checks = 0;
    int errors = 0;

    score_counter #(.TICKS_PER_POINT(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .game_start (game_start),
        .game_over  (game_over),
        .digit_sel  (digit_sel),
        .digit_addr (digit_addr),
        .score_bcd  (score_bcd),
        .hi_bcd     (hi_bcd),
        .running    (running),
        .milestone  (milestone)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start_game();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic end_game();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score got %h exp 0000", score_bcd); end
        checks++; if (hi_bcd !== 16'h0000) begin errors++; $display("FAIL reset_hi got %h exp 0000", hi_bcd); end
        checks++; if ({running, milestone, digit_addr} !== 6'd0) begin errors++; $display("FAIL reset_flags got run=%b ms=%b addr=%0d exp 0", running, milestone, digit_addr); end
        step();
        rst = 1'b0;
        do_ticks(12);
        checks++; if (score_bcd !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL idle_tick got %h run=%b exp 0000 run=0", score_bcd, running); end
    endtask

    task automatic test_count();
        start_game();
        checks++; if (running !== 1'b1 || score_bcd !== 16'h0000) begin errors++; $display("FAIL start got run=%b %h exp run=1 0000", running, score_bcd); end
        do_ticks(5);
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL five_ticks got %h exp 0000", score_bcd); end
        do_ticks(1);
        checks++; if (score_bcd !== 16'h0001 || running !== 1'b1) begin errors++; $display("FAIL six_ticks got %h run=%b exp 0001 run=1", score_bcd, running); end
        do_ticks(54);
        checks++; if (score_bcd !== 16'h0010) begin errors++; $display("FAIL sixty_ticks got %h exp 0010", score_bcd); end
        start_game();
        checks++; if (score_bcd !== 16'h0010 || running !== 1'b1) begin errors++; $display("FAIL start_in_run got %h run=%b exp 0010 run=1", score_bcd, running); end
    endtask

    task automatic test_milestone();
        int ms_cnt;
        do_reset();
        start_game();
        ms_cnt = 0;
        tick = 1'b1;
        for (int i = 0; i < 594; i++) begin
            step();
            if (milestone === 1'b1) ms_cnt++;
        end
        tick = 1'b0;
        checks++; if (score_bcd !== 16'h0099 || ms_cnt != 0) begin errors++; $display("FAIL to_0099 got %h ms=%0d exp 0099 ms=0", score_bcd, ms_cnt); end
        do_ticks(5);
        checks++; if (milestone !== 1'b0) begin errors++; $display("FAIL early_ms got %b exp 0", milestone); end
        do_ticks(1);
        checks++; if (score_bcd !== 16'h0100 || milestone !== 1'b1) begin errors++; $display("FAIL ms_0100 got %h ms=%b exp 0100 ms=1", score_bcd, milestone); end
        step();
        checks++; if (milestone !== 1'b0) begin errors++; $display("FAIL ms_one_cycle got %b exp 0", milestone); end
    endtask

    task automatic test_hiscore();
        do_reset();
        start_game();
        do_ticks(252);
        checks++; if (score_bcd !== 16'h0042) begin errors++; $display("FAIL score_0042 got %h exp 0042", score_bcd); end
        end_game();
        checks++; if (hi_bcd !== 16'h0042 || running !== 1'b0) begin errors++; $display("FAIL hi_load got %h run=%b exp 0042 run=0", hi_bcd, running); end
        do_ticks(12);
        end_game();
        checks++; if (score_bcd !== 16'h0042 || hi_bcd !== 16'h0042) begin errors++; $display("FAIL over_frozen got %h hi=%h exp 0042 hi=0042", score_bcd, hi_bcd); end
        digit_sel = 3'd5;
        step();
        checks++; if (digit_addr !== 4'd4) begin errors++; $display("FAIL hi_tens got %0d exp 4", digit_addr); end
        digit_sel = 3'd6;
        step();
        checks++; if (digit_addr !== 4'd10) begin errors++; $display("FAIL hi_hundreds got %0d exp 10", digit_addr); end
        start_game();
        do_ticks(180);
        checks++; if (score_bcd !== 16'h0030) begin errors++; $display("FAIL score_0030 got %h exp 0030", score_bcd); end
        end_game();
        checks++; if (hi_bcd !== 16'h0042) begin errors++; $display("FAIL hi_keep got %h exp 0042", hi_bcd); end
    endtask

    task automatic test_saturate();
        int ms_cnt;
        do_reset();
        start_game();
        ms_cnt = 0;
        tick = 1'b1;
        for (int i = 0; i < 59994; i++) begin
            step();
            if (milestone === 1'b1) ms_cnt++;
        end
        checks++; if (score_bcd !== 16'h9999 || ms_cnt != 99) begin errors++; $display("FAIL to_9999 got %h ms=%0d exp 9999 ms=99", score_bcd, ms_cnt); end
        ms_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (milestone === 1'b1) ms_cnt++;
        end
        tick = 1'b0;
        checks++; if (score_bcd !== 16'h9999 || ms_cnt != 0) begin errors++; $display("FAIL saturate got %h ms=%0d exp 9999 ms=0", score_bcd, ms_cnt); end
        digit_sel = 3'd3;
        step();
        checks++; if (digit_addr !== 4'd9) begin errors++; $display("FAIL thousands_9 got %0d exp 9", digit_addr); end
    endtask

    task automatic test_digits();
        do_reset();
        start_game();
        do_ticks(42);
        digit_sel = 3'd0;
        step();
        checks++; if (digit_addr !== 4'd7) begin errors++; $display("FAIL sel0 got %0d exp 7", digit_addr); end
        digit_sel = 3'd1;
        #1;
        checks++; if (digit_addr !== 4'd7) begin errors++; $display("FAIL sel_latency got %0d exp 7", digit_addr); end
        step();
        checks++; if (digit_addr !== 4'd10) begin errors++; $display("FAIL sel1 got %0d exp 10", digit_addr); end
        digit_sel = 3'd3;
        step();
        checks++; if (digit_addr !== 4'd10) begin errors++; $display("FAIL sel3 got %0d exp 10", digit_addr); end
        digit_sel = 3'd4;
        step();
        checks++; if (digit_addr !== 4'd0) begin errors++; $display("FAIL sel4 got %0d exp 0", digit_addr); end
        end_game();
        start_game();
        digit_sel = 3'd0;
        step();
        checks++; if (score_bcd !== 16'h0000 || digit_addr !== 4'd0) begin errors++; $display("FAIL zero_units got %h addr=%0d exp 0000 addr=0", score_bcd, digit_addr); end
    endtask

    task automatic test_collision();
        do_reset();
        start_game();
        do_ticks(35);
        checks++; if (score_bcd !== 16'h0005) begin errors++; $display("FAIL pre_collide got %h exp 0005", score_bcd); end
        tick = 1'b1;
        game_over = 1'b1;
        step();
        tick = 1'b0;
        game_over = 1'b0;
        checks++; if (score_bcd !== 16'h0005 || hi_bcd !== 16'h0005 || running !== 1'b0) begin errors++; $display("FAIL collide got %h hi=%h run=%b exp 0005 hi=0005 run=0", score_bcd, hi_bcd, running); end
        start_game();
        digit_sel = 3'd4;
        do_ticks(10);
        checks++; if (score_bcd !== 16'h0001 || digit_addr !== 4'd5) begin errors++; $display("FAIL second_game got %h addr=%0d exp 0001 addr=5", score_bcd, digit_addr); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({score_bcd, hi_bcd} !== 32'd0 || {running, milestone, digit_addr} !== 6'd0) begin errors++; $display("FAIL mid_rst got %h hi=%h run=%b ms=%b addr=%0d exp all 0", score_bcd, hi_bcd, running, milestone, digit_addr); end
        step();
        rst = 1'b0;
        end_game();
        do_ticks(12);
        checks++; if (running !== 1'b0 || score_bcd !== 16'h0000) begin errors++; $display("FAIL post_rst_idle got run=%b %h exp run=0 0000", running, score_bcd); end
    endtask

    initial begin
        #1;
        test_reset();
        test_count();
        test_milestone();
        test_hiscore();
        test_digits();
        test_collision();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 SHALL have parameter TICKS_PER_POINT, default 6, meaning frame ticks per score point (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle frame pulse.
REQ-005 SHALL have port game_start  input  1  one-cycle start request.
REQ-006 SHALL have port game_over  input  1  one-cycle collision/end request.
REQ-007 SHALL have port digit_sel  input  3  digit select: 0-3 = score units..thousands, 4-7 = high-score units..thousands.
REQ-008 SHALL have port digit_addr  output  4  registered glyph address for the downstream digit ROM (0-9 digit, 10 blank).
REQ-009 SHALL have port score_bcd  output  16  current score, 4 packed BCD digits, thousands in [15:12].
REQ-010 SHALL have port hi_bcd  output  16  high score, packed BCD.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port milestone  output  1  one-cycle pulse on each 100-point crossing.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, OVER; running = (state == RUN).
REQ-014 IDLE or OVER + game_start SHALL go to RUN next cycle, clearing score_bcd and prescaler to 0.
REQ-015 RUN + game_over SHALL go to OVER; game_over takes priority over game_start and tick in the same cycle.
REQ-016 game_over and game_start outside their legal states SHALL be ignored.
REQ-017 In RUN, tick SHALL advance an 8-bit prescaler; on tick with prescaler == TICKS_PER_POINT-1, prescaler SHALL reset to 0 and score SHALL increment by 1 (BCD, ripple carry units->thousands).
REQ-018 Score SHALL saturate at 9999; further points leave score unchanged and generate no milestone.
REQ-019 milestone SHALL pulse for exactly one cycle, registered, in the cycle after score changes to a value whose units and tens are both 0.
REQ-020 On the RUN->OVER transition, hi_bcd SHALL load score_bcd if score_bcd > hi_bcd (unsigned compare of packed BCD); the compare uses the pre-update score (a point due in the same cycle is discarded).
REQ-021 hi_bcd SHALL persist across games and change only via REQ-020 or reset.
REQ-022 tick outside RUN SHALL not change score or prescaler.
REQ-023 digit_addr SHALL equal the selected BCD digit, registered one cycle after digit_sel (ROM adds one more cycle: 2-cycle sel-to-segments).
REQ-024 Leading-zero blanking: selected digit SHALL map to address 10 when it and all higher digits of the same number are 0, except units, which always shows its value.
REQ-025 Outputs SHALL never present non-BCD digit values (A-F).

Reset
REQ-026 rst SHALL asynchronously force: state IDLE, score_bcd 0, hi_bcd 0, prescaler 0, digit_addr 0, milestone 0, running 0.
REQ-027 rst asserted mid-game SHALL discard score and high score; first post-reset edge SHALL behave as IDLE.

Structure
REQ-028 Shared package score_pkg SHALL hold the state enum, BCD digit type, BLANK_ADDR = 10, MAX_SCORE = 16'h9999.
REQ-029 One sub-module bcd_digit (4-bit BCD counter with inc, clear, carry-out) SHALL be instantiated four times.
REQ-030 Prescaler, FSM, high-score compare and digit mux SHALL live in score_counter; no combinational path from inputs to outputs.

Verification
REQ-031 Reset, game_start, 6 ticks -> score_bcd 16'h0001, running 1; 60 ticks total -> 16'h0010.
REQ-032 Preload path to 0099 then 6 ticks -> score 16'h0100, milestone high exactly one cycle.
REQ-033 Score 0042, game_over -> OVER, hi_bcd 16'h0042; new game reaching 0030 then over -> hi_bcd stays 16'h0042.
REQ-034 Score 9999, 12 ticks -> score stays 16'h9999, no milestone.
REQ-035 Score 0007, digit_sel 0,1,3 -> digit_addr 7,10,10 each one cycle later; score 0000 digit_sel 0 -> 0.
REQ-036 game_over coincident with a point tick at score 0005 -> hi_bcd 16'h0005, score 16'h0005; rst mid-RUN -> all outputs 0, IDLE.
